// File: rtl/scan_mux_ctrl.sv
// Time-multiplexed display scanner: per-slot blanking, enable mask, frame-coherent shadow.
// Optional build macro SCAN_DIM_EN adds a live duty input that trims the lit part of each slot.
module scan_mux_ctrl #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int DIV     = 8,
  parameter int BLANK   = 2
) (
  input  logic                                          clk,
  input  logic                                          res,
  input  logic [DIGITS*DIGIT_W-1:0]                     ans,
  input  logic [DIGITS-1:0]                             en_mask,
`ifdef SCAN_DIM_EN
  input  logic [$clog2(DIV-BLANK+1)-1:0]                duty,
`endif
  output logic [DIGITS-1:0]                             ano,
  output logic [DIGIT_W-1:0]                            digit,
  output logic [(($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1)-1:0] idx,
  output logic                                          frame_done
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [CNT_W-1:0]            cnt_r;
  logic [CNT_W-1:0]            cnt_nxt_s;
  logic [IDX_W-1:0]            idx_r;
  logic [IDX_W-1:0]            idx_nxt_s;
  logic [DIGITS*DIGIT_W-1:0]   shadow_r;
  logic                        load_s;
  logic                        show_s;
  logic                        duty_ok_s;
  logic                        lit_s;

  // Next-state: wrap compares use >= so out-of-range cnt/idx fall back to 0.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_ONE;
    idx_nxt_s   = idx_r;
    if (cnt_r >= CNT_LAST) begin
      cnt_nxt_s   = '0;
      state_nxt_s = ST_BLANK;
      if (idx_r >= IDX_LAST) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + IDX_ONE;
      end
    end else if (cnt_r == BLANK_LAST) begin
      state_nxt_s = ST_SHOW;
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign load_s = (state_r == ST_BLANK) && (cnt_r == '0) && (idx_r == '0);

  // State, slot counter, slot index and the frame shadow of the display word.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r  <= ST_BLANK;
      cnt_r    <= '0;
      idx_r    <= '0;
      shadow_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      if (load_s) begin
        shadow_r <= ans;
      end
    end
  end

  // Phase decode from the registered state.
  always_comb begin
    show_s = 1'b0;
    case (state_r)
      ST_SHOW:  show_s = 1'b1;
      ST_BLANK: show_s = 1'b0;
      default:  show_s = 1'b0;
    endcase
  end

`ifdef SCAN_DIM_EN
  // In SHOW cnt >= BLANK, so the offset into the lit phase never underflows.
  assign duty_ok_s = (({1'b0, cnt_r} - (CNT_W+1)'(BLANK)) < (CNT_W+1)'(duty));
`else
  assign duty_ok_s = 1'b1;
`endif

  assign lit_s = show_s && duty_ok_s;

  // One-hot enable; an index outside 0..DIGITS-1 matches no bit and stays dark.
  always_comb begin
    ano = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ano[i] = lit_s && en_mask[i] && (idx_r == IDX_W'(i));
    end
  end

  // Digit code of the current slot, taken from the frame shadow.
  always_comb begin
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = (idx_r == IDX_W'(i)) ? shadow_r[i*DIGIT_W +: DIGIT_W] : digit;
    end
  end

  // Frame end marker in the final cycle of the last slot.
  always_comb begin
    frame_done = show_s && (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
  end

  assign idx = idx_r;

endmodule

// File: tb/tb_scan_mux_ctrl.sv
// Scoreboard bench for scan_mux_ctrl: default build plus a DIGITS=6/DIV=5/BLANK=1 instance.
module tb_scan_mux_ctrl;

  localparam int D1 = 4;
  localparam int V1 = 8;
  localparam int B1 = 2;
  localparam int D2 = 6;
  localparam int V2 = 5;
  localparam int B2 = 1;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] ans;
  logic [3:0]  en_mask;
  logic [3:0]  ano;
  logic [3:0]  digit;
  logic [1:0]  idx;
  logic        frame_done;
  logic [23:0] ans2;
  logic [5:0]  mask2;
  logic [5:0]  ano2;
  logic [3:0]  digit2;
  logic [2:0]  idx2;
  logic        fd2;
`ifdef SCAN_DIM_EN
  logic [2:0]  duty;
  logic [2:0]  duty2;
`endif

  typedef struct packed {
    logic [7:0] ano;
    logic [7:0] digit;
    logic [7:0] idx;
    logic       fd;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int          t;
  logic [31:0] shadow1;
  logic [31:0] shadow2;
  int          dty1;
  int          dty2;
  int          fd1_cnt;
  int          fd2_cnt;
  int          on2_cnt;
  int          hit1[4];

  always #5 clk = ~clk;

  scan_mux_ctrl #(.DIGITS(D1), .DIGIT_W(4), .DIV(V1), .BLANK(B1)) dut (
    .clk(clk), .res(res), .ans(ans), .en_mask(en_mask),
`ifdef SCAN_DIM_EN
    .duty(duty),
`endif
    .ano(ano), .digit(digit), .idx(idx), .frame_done(frame_done)
  );

  scan_mux_ctrl #(.DIGITS(D2), .DIGIT_W(4), .DIV(V2), .BLANK(B2)) dut2 (
    .clk(clk), .res(res), .ans(ans2), .en_mask(mask2),
`ifdef SCAN_DIM_EN
    .duty(duty2),
`endif
    .ano(ano2), .digit(digit2), .idx(idx2), .frame_done(fd2)
  );

  // Expected outputs for cycle tc after reset release, from slot/position arithmetic.
  function automatic exp_t model(input int tc, input int nd, input int nv, input int nb,
                                 input logic [31:0] msk, input logic [31:0] shw, input int dty);
    exp_t e;
    int   slot;
    int   pos;
    slot    = (tc / nv) % nd;
    pos     = tc % nv;
    e.idx   = 8'(slot);
    e.ano   = ((pos >= nb) && msk[slot] && ((pos - nb) < dty)) ? 8'(1 << slot) : 8'h00;
    e.digit = 8'((shw >> (slot * 4)) & 32'h0000_000F);
    e.fd    = (pos == nv - 1) && (slot == nd - 1);
    return e;
  endfunction

  task automatic step(input int n, input int chg_t, input logic [15:0] chg_val);
    exp_t e1;
    exp_t e2;
    for (int k = 0; k < n; k++) begin
      if (t == chg_t) ans = chg_val;
      sb.push_back(model(t, D1, V1, B1, 32'(en_mask), shadow1, dty1));
      sb.push_back(model(t, D2, V2, B2, 32'(mask2), shadow2, dty2));
      if (t % (D1 * V1) == 0) shadow1 = 32'(ans);
      if (t % (D2 * V2) == 0) shadow2 = 32'(ans2);
      #1;
      e1 = sb.pop_front();
      e2 = sb.pop_front();
      checks++;
      if ({4'h0, ano} !== e1.ano || {4'h0, digit} !== e1.digit ||
          {6'h0, idx} !== e1.idx || frame_done !== e1.fd) begin
        errors++;
        $display("FAIL scan4 t=%0d ano %b want %b digit %h want %h idx %0d want %0d fd %b want %b",
                 t, ano, e1.ano[3:0], digit, e1.digit[3:0], idx, e1.idx, frame_done, e1.fd);
      end
      checks++;
      if ({2'h0, ano2} !== e2.ano || {4'h0, digit2} !== e2.digit ||
          {5'h0, idx2} !== e2.idx || fd2 !== e2.fd) begin
        errors++;
        $display("FAIL scan6 t=%0d ano %b want %b digit %h want %h idx %0d want %0d fd %b want %b",
                 t, ano2, e2.ano[5:0], digit2, e2.digit[3:0], idx2, e2.idx, fd2, e2.fd);
      end
      fd1_cnt += int'(frame_done);
      fd2_cnt += int'(fd2);
      on2_cnt += int'(ano2 != 6'h00);
      for (int i = 0; i < 4; i++) hit1[i] += int'(ano[i]);
      t++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    res = 1'b0;
    #1;
    checks++;
    if (ano !== 4'h0 || idx !== 2'd0 || digit !== 4'h0 || frame_done !== 1'b0 ||
        ano2 !== 6'h00 || idx2 !== 3'd0 || digit2 !== 4'h0 || fd2 !== 1'b0) begin
      errors++;
      $display("FAIL reset ano %b idx %0d digit %h fd %b ano2 %b idx2 %0d digit2 %h fd2 %b want all 0",
               ano, idx, digit, frame_done, ano2, idx2, digit2, fd2);
    end
    @(negedge clk);
    @(negedge clk);
    res     = 1'b1;
    t       = 0;
    shadow1 = 32'h0;
    shadow2 = 32'h0;
    fd1_cnt = 0;
    fd2_cnt = 0;
    on2_cnt = 0;
    for (int i = 0; i < 4; i++) hit1[i] = 0;
    sb.delete();
  endtask

  task automatic test_reset_first_frame();
    ans     = 16'h4321;
    en_mask = 4'hF;
    apply_reset();
    step(33, -1, 16'h0);
    checks++;
    if (fd1_cnt != 1 || hit1[0] != 6 || hit1[1] != 6 || hit1[2] != 6 || hit1[3] != 6) begin
      errors++;
      $display("FAIL first_frame fd_count %0d want 1 lit %0d %0d %0d %0d want 6 each",
               fd1_cnt, hit1[0], hit1[1], hit1[2], hit1[3]);
    end
  endtask

  task automatic test_coherence();
    ans     = 16'h4321;
    en_mask = 4'hF;
    apply_reset();
    step(64, 12, 16'hABCD);
  endtask

  task automatic test_mask();
    ans     = 16'h4321;
    en_mask = 4'b0101;
    apply_reset();
    step(64, -1, 16'h0);
    checks++;
    if (hit1[1] != 0 || hit1[3] != 0 || hit1[0] != 12 || hit1[2] != 12 || fd1_cnt != 2) begin
      errors++;
      $display("FAIL mask lit %0d %0d %0d %0d want 12 0 12 0 fd_count %0d want 2",
               hit1[0], hit1[1], hit1[2], hit1[3], fd1_cnt);
    end
    en_mask = 4'hF;
  endtask

  task automatic test_async_reset();
    ans     = 16'h4321;
    en_mask = 4'hF;
    apply_reset();
    step(20, -1, 16'h0);
    #2;
    checks++;
    if (ano !== 4'b0100 || digit !== 4'h3 || idx !== 2'd2) begin
      errors++;
      $display("FAIL pre_abort ano %b want 0100 digit %h want 3 idx %0d want 2", ano, digit, idx);
    end
    apply_reset();
    step(33, -1, 16'h0);
    checks++;
    if (fd1_cnt != 1 || hit1[0] != 6 || hit1[3] != 6) begin
      errors++;
      $display("FAIL restart fd_count %0d want 1 lit0 %0d lit3 %0d want 6", fd1_cnt, hit1[0], hit1[3]);
    end
  endtask

  task automatic test_npow2();
    ans2  = 24'h65_4321;
    mask2 = 6'h3F;
    apply_reset();
    step(60, -1, 16'h0);
    checks++;
    if (fd2_cnt != 2 || on2_cnt != 48) begin
      errors++;
      $display("FAIL npow2 fd_count %0d want 2 lit_cycles %0d want 48", fd2_cnt, on2_cnt);
    end
  endtask

`ifdef SCAN_DIM_EN
  task automatic test_dim();
    int dv[3];
    int want[3];
    dv[0] = 3; dv[1] = 0; dv[2] = 6;
    want[0] = 3; want[1] = 0; want[2] = 6;
    en_mask = 4'hF;
    for (int j = 0; j < 3; j++) begin
      duty = 3'(dv[j]);
      dty1 = dv[j];
      apply_reset();
      step(32, -1, 16'h0);
      checks++;
      if (hit1[0] != want[j] || hit1[3] != want[j]) begin
        errors++;
        $display("FAIL dim duty %0d lit0 %0d lit3 %0d want %0d", dv[j], hit1[0], hit1[3], want[j]);
      end
    end
    duty = 3'd6;
    dty1 = 6;
  endtask
`endif

  initial begin
    res     = 1'b1;
    ans     = 16'h4321;
    en_mask = 4'hF;
    ans2    = 24'h65_4321;
    mask2   = 6'h3F;
    checks  = 0;
    errors  = 0;
    t       = 0;
    dty1    = V1 - B1;
    dty2    = V2 - B2;
`ifdef SCAN_DIM_EN
    duty    = 3'd6;
    duty2   = 3'd4;
`endif
    #2;
    test_reset_first_frame();
    test_coherence();
    test_mask();
    test_async_reset();
    test_npow2();
`ifdef SCAN_DIM_EN
    test_dim();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
